// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle RV32I integer ops plus iterative RV32M multiply/divide.
// Operands are latched on accept; result and branch flags are registered together.
module alu_multicycle #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] ALUop1,
    input  logic                  ALUsrc,
    input  logic [DATA_WIDTH-1:0] regOp2,
    input  logic [DATA_WIDTH-1:0] ImmOp,
    input  logic [3:0]            ALUctrl,
    input  logic                  kill,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] ALUout,
    output logic                  Zero,
    output logic                  Eq,
    output logic                  Lt,
    output logic                  Ltu
);

    localparam int W   = DATA_WIDTH;
    localparam int SHW = $clog2(DATA_WIDTH);

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SLL   = 4'b0101;
    localparam logic [3:0] OP_SRL   = 4'b0110;
    localparam logic [3:0] OP_SRA   = 4'b0111;
    localparam logic [3:0] OP_SLT   = 4'b1000;
    localparam logic [3:0] OP_SLTU  = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1010;
    localparam logic [3:0] OP_MULHU = 4'b1011;

    localparam logic [W-1:0] MIN_NEG  = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] ALL_ONES = {W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    // Magnitude of a value, treating it as two's complement only when sgn is set.
    function automatic logic [W-1:0] mag(input logic [W-1:0] v, input logic sgn);
        return (sgn && v[W-1]) ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [W-1:0] neg_if(input logic [W-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    state_t               state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [3:0]           op_q;
    logic [W-1:0]         a_q;
    logic [W-1:0]         b_q;
    logic [2*W-1:0]       work_q;
    logic                 out_valid_q;
    logic [W-1:0]         alu_out_q;
    logic                 zero_q;
    logic                 eq_q;
    logic                 lt_q;
    logic                 ltu_q;

    logic [W-1:0]         opb_in;
    logic                 is_mul_in;
    logic                 is_div_in;
    logic                 div_signed_in;
    logic                 div_fast_in;
    logic [W-1:0]         dividend_in;

    logic [W:0]           mul_sum;
    logic [2*W-1:0]       work_mul_d;
    logic [W-1:0]         divisor;
    logic [W:0]           div_shift;
    logic [W:0]           div_diff;
    logic [2*W-1:0]       work_div_d;

    logic signed [W-1:0]  a_s;
    logic signed [W-1:0]  b_s;
    logic [SHW-1:0]       shamt;
    logic                 lt_c;
    logic                 ltu_c;
    logic [W-1:0]         result_d;

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign ALUout    = alu_out_q;
    assign Zero      = zero_q;
    assign Eq        = eq_q;
    assign Lt        = lt_q;
    assign Ltu       = ltu_q;

    // Accept-side decode on the live inputs
    assign opb_in        = ALUsrc ? ImmOp : regOp2;
    assign is_mul_in     = (ALUctrl == OP_MUL) || (ALUctrl == OP_MULHU);
    assign is_div_in     = (ALUctrl[3:2] == 2'b11);
    assign div_signed_in = ALUctrl[1];
    assign div_fast_in   = (opb_in == '0) ||
                           (div_signed_in && (ALUop1 == MIN_NEG) && (opb_in == ALL_ONES));
    assign dividend_in   = mag(ALUop1, div_signed_in);

    // Shift-add multiply: {hi, lo} where lo starts as the multiplier and drains right.
    assign mul_sum    = {1'b0, work_q[2*W-1:W]} + (work_q[0] ? {1'b0, a_q} : '0);
    assign work_mul_d = {mul_sum, work_q[W-1:1]};

    // Restoring divide: {remainder, quotient}; dividend bits shift out of the low half.
    assign divisor    = mag(b_q, op_q[1]);
    assign div_shift  = {work_q[2*W-1:W], work_q[W-1]};
    assign div_diff   = div_shift - {1'b0, divisor};
    assign work_div_d = div_diff[W] ? {div_shift[W-1:0], work_q[W-2:0], 1'b0}
                                    : {div_diff[W-1:0],  work_q[W-2:0], 1'b1};

    assign a_s   = a_q;
    assign b_s   = b_q;
    assign shamt = b_q[SHW-1:0];
    assign lt_c  = a_s < b_s;
    assign ltu_c = a_q < b_q;

    always_comb begin
        result_d = '0;
        case (op_q)
            OP_ADD:   result_d = a_q + b_q;
            OP_SUB:   result_d = a_q - b_q;
            OP_AND:   result_d = a_q & b_q;
            OP_OR:    result_d = a_q | b_q;
            OP_XOR:   result_d = a_q ^ b_q;
            OP_SLL:   result_d = a_q << shamt;
            OP_SRL:   result_d = a_q >> shamt;
            OP_SRA:   result_d = a_s >>> shamt;
            OP_SLT:   result_d = {{(W-1){1'b0}}, lt_c};
            OP_SLTU:  result_d = {{(W-1){1'b0}}, ltu_c};
            OP_MUL:   result_d = work_q[W-1:0];
            OP_MULHU: result_d = work_q[2*W-1:W];
            default: begin
                // Divide family: bit1 = signed, bit0 = remainder
                if (b_q == '0) begin
                    result_d = op_q[0] ? a_q : ALL_ONES;
                end else if (op_q[1] && (a_q == MIN_NEG) && (b_q == ALL_ONES)) begin
                    result_d = op_q[0] ? '0 : a_q;
                end else if (op_q[0]) begin
                    result_d = neg_if(work_q[2*W-1:W], op_q[1] && a_q[W-1]);
                end else begin
                    result_d = neg_if(work_q[W-1:0], op_q[1] && (a_q[W-1] ^ b_q[W-1]));
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            alu_out_q   <= '0;
            zero_q      <= 1'b1;
            eq_q        <= 1'b0;
            lt_q        <= 1'b0;
            ltu_q       <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (kill) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (in_valid) begin
                            op_q <= ALUctrl;
                            a_q  <= ALUop1;
                            b_q  <= opb_in;
                            if (is_mul_in) begin
                                work_q  <= {{W{1'b0}}, opb_in};
                                cnt_q   <= CNT_WIDTH'(W);
                                state_q <= S_MUL;
                            end else if (is_div_in && !div_fast_in) begin
                                work_q  <= {{W{1'b0}}, dividend_in};
                                cnt_q   <= CNT_WIDTH'(W);
                                state_q <= S_DIV;
                            end else begin
                                state_q <= S_DONE;
                            end
                        end
                    end
                    S_MUL: begin
                        work_q <= work_mul_d;
                        cnt_q  <= cnt_q - CNT_WIDTH'(1);
                        if (cnt_q == CNT_WIDTH'(1)) begin
                            state_q <= S_DONE;
                        end
                    end
                    S_DIV: begin
                        work_q <= work_div_d;
                        cnt_q  <= cnt_q - CNT_WIDTH'(1);
                        if (cnt_q == CNT_WIDTH'(1)) begin
                            state_q <= S_DONE;
                        end
                    end
                    default: begin
                        out_valid_q <= 1'b1;
                        alu_out_q   <= result_d;
                        zero_q      <= (result_d == '0);
                        eq_q        <= (a_q == b_q);
                        lt_q        <= lt_c;
                        ltu_q       <= ltu_c;
                        state_q     <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
